// File: rtl/axi_esdi_write_datapath_if.sv
// axi_esdi_write_datapath_if: AXI4-Lite CSR channels plus the AXI4-Stream byte channel
interface axi_esdi_write_datapath_if;
   logic        csr_awvalid, csr_awready;
   logic [4:0]  csr_awaddr;
   logic        csr_wvalid, csr_wready;
   logic [31:0] csr_wdata;
   logic        csr_bvalid, csr_bready;
   logic [1:0]  csr_bresp;
   logic        csr_arvalid, csr_arready;
   logic [4:0]  csr_araddr;
   logic        csr_rvalid, csr_rready;
   logic [31:0] csr_rdata;
   logic [1:0]  csr_rresp;
   logic        s_tvalid, s_tready, s_tlast;
   logic [7:0]  s_tdata;
   modport master (
      output csr_awvalid, csr_awaddr, csr_wvalid, csr_wdata, csr_bready,
             csr_arvalid, csr_araddr, csr_rready, s_tvalid, s_tdata, s_tlast,
      input  csr_awready, csr_wready, csr_bvalid, csr_bresp, csr_arready,
             csr_rvalid, csr_rdata, csr_rresp, s_tready
   );
   modport slave (
      input  csr_awvalid, csr_awaddr, csr_wvalid, csr_wdata, csr_bready,
             csr_arvalid, csr_araddr, csr_rready, s_tvalid, s_tdata, s_tlast,
      output csr_awready, csr_wready, csr_bvalid, csr_bresp, csr_arready,
             csr_rvalid, csr_rdata, csr_rresp, s_tready
   );
endinterface

// File: rtl/axi_esdi_write_datapath.sv
// axi_esdi_write_datapath: serializes AXI-Stream bytes MSB-first onto the ESDI NRZ write line
// with write gate and write clock; AXI4-Lite CSRs select the bit clock and report status.
module axi_esdi_write_datapath #(
   parameter int MAX_BYTES_PER_PACKET = 2048
) (
   input  logic                            aclk,
   input  logic                            areset,
   axi_esdi_write_datapath_if.slave        bus,
   input  logic                            esdi_reference_clock_i,
   output logic                            esdi_write_gate_o,
   output logic                            esdi_write_data_o,
   output logic                            esdi_write_clock_o
);
   localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, SHIFT = 2'd2, DRAIN = 2'd3;
   localparam logic [15:0] LAST_IDX = 16'(MAX_BYTES_PER_PACKET - 1);

   logic        aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, b_valid_q, b_valid_d, r_valid_q, r_valid_d;
   logic [2:0]  aw_addr_q, aw_addr_d;
   logic [7:0]  w_data_q, w_data_d;
   logic [31:0] r_data_q, r_data_d, rd_mux;
   logic        enable_q, enable_d, use_int_q, use_int_d, underrun_q, underrun_d;
   logic [7:0]  cpb_q, cpb_d, cpb_eff, cnt_q, cnt_d;
   logic [15:0] count_q, count_d, byte_cnt_q, byte_cnt_d;
   logic [2:0]  sync_q, sync_d, bit_cnt_q, bit_cnt_d;
   logic        wclk_q, wclk_d, gate_q, gate_d, data_q, data_d, last_q, last_d;
   logic [1:0]  state_q, state_d;
   logic [7:0]  shift_q, shift_d, hold_q, hold_d;
   logic        hold_last_q, hold_last_d, hold_valid_q, hold_valid_d;
   logic        wr_fire, wr0, wr1, ar_fire, clr_underrun, set_underrun;
   logic        run, wrap, tick, tready, s_acc, fill, take;

   assign wr_fire = aw_valid_q && w_valid_q && !b_valid_q;
   assign wr0 = wr_fire && aw_addr_q == 3'd0;
   assign wr1 = wr_fire && aw_addr_q == 3'd1;
   assign ar_fire = bus.csr_arvalid && !r_valid_q;
   assign clr_underrun = wr0 && w_data_q[2];

   assign aw_valid_d = wr_fire ? 1'b0 : aw_valid_q || bus.csr_awvalid;
   assign aw_addr_d = (!aw_valid_q && bus.csr_awvalid) ? bus.csr_awaddr[4:2] : aw_addr_q;
   assign w_valid_d = wr_fire ? 1'b0 : w_valid_q || bus.csr_wvalid;
   assign w_data_d = (!w_valid_q && bus.csr_wvalid) ? bus.csr_wdata[7:0] : w_data_q;
   assign b_valid_d = wr_fire || (b_valid_q && !bus.csr_bready);
   assign r_valid_d = ar_fire || (r_valid_q && !bus.csr_rready);
   assign rd_mux = bus.csr_araddr[4:2] == 3'd0 ? {30'd0, use_int_q, enable_q} :
                   bus.csr_araddr[4:2] == 3'd1 ? {24'd0, cpb_q} :
                   bus.csr_araddr[4:2] == 3'd2 ? {count_q, 14'd0, underrun_q, gate_q} : 32'd0;
   assign r_data_d = ar_fire ? rd_mux : r_data_q;
   assign enable_d = wr0 ? w_data_q[0] : enable_q;
   assign use_int_d = wr0 ? w_data_q[1] : use_int_q;
   assign cpb_d = wr1 ? w_data_q : cpb_q;
   // A new underrun in the same cycle as a clear must survive.
   assign underrun_d = set_underrun || (underrun_q && !clr_underrun);

   assign bus.csr_awready = !aw_valid_q;
   assign bus.csr_wready = !w_valid_q;
   assign bus.csr_bvalid = b_valid_q;
   assign bus.csr_bresp = 2'b00;
   assign bus.csr_arready = !r_valid_q;
   assign bus.csr_rvalid = r_valid_q;
   assign bus.csr_rdata = r_data_q;
   assign bus.csr_rresp = 2'b00;

   assign cpb_eff = cpb_q < 8'd2 ? 8'd2 : cpb_q;
   assign run = enable_q && use_int_q;
   assign wrap = cnt_q >= cpb_eff - 8'd1;
   assign cnt_d = (run && !wrap) ? cnt_q + 8'd1 : 8'd0;
   assign sync_d = {sync_q[1:0], esdi_reference_clock_i};
   assign tick = use_int_q ? run && wrap : sync_q[2] && !sync_q[1];
   // Registered from the same stage pair as the tick so the clock edge lines up with data updates.
   assign wclk_d = use_int_q ? run && cnt_d >= {1'b0, cpb_eff[7:1]} : sync_q[1];

   assign tready = state_q == DRAIN || (enable_q && !hold_valid_q);
   assign s_acc = bus.s_tvalid && tready;
   assign fill = s_acc && state_q != DRAIN;
   assign hold_d = fill ? bus.s_tdata : hold_q;
   assign hold_last_d = fill ? bus.s_tlast : hold_last_q;
   assign bus.s_tready = tready;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      last_d = last_q;
      bit_cnt_d = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      gate_d = gate_q;
      data_d = data_q;
      count_d = count_q;
      set_underrun = 1'b0;
      take = 1'b0;
      hold_valid_d = hold_valid_q || fill;
      if ((state_q == ARM || state_q == SHIFT) && !enable_q) begin
         gate_d = 1'b0;
         data_d = 1'b0;
         set_underrun = 1'b1;
         hold_valid_d = 1'b0;
         state_d = DRAIN;
      end else if (state_q == IDLE) begin
         if (hold_valid_q) begin
            take = 1'b1;
            shift_d = hold_q;
            last_d = hold_last_q;
            bit_cnt_d = 3'd0;
            byte_cnt_d = 16'd0;
            state_d = ARM;
         end
      end else if (state_q == ARM) begin
         if (tick) begin
            gate_d = 1'b1;
            data_d = shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
            bit_cnt_d = 3'd0;
            state_d = SHIFT;
         end
      end else if (state_q == SHIFT) begin
         if (tick && bit_cnt_q != 3'd7) begin
            data_d = shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
         end else if (tick && (last_q || byte_cnt_q == LAST_IDX)) begin
            gate_d = 1'b0;
            data_d = 1'b0;
            count_d = byte_cnt_q + 16'd1;
            state_d = IDLE;
         end else if (tick && hold_valid_q) begin
            take = 1'b1;
            data_d = hold_q[7];
            shift_d = {hold_q[6:0], 1'b0};
            last_d = hold_last_q;
            bit_cnt_d = 3'd0;
            byte_cnt_d = byte_cnt_q + 16'd1;
         end else if (tick) begin
            set_underrun = 1'b1;
            gate_d = 1'b0;
            data_d = 1'b0;
            state_d = DRAIN;
         end
      end else if (s_acc && bus.s_tlast) begin
         state_d = IDLE;
      end
      if (take) hold_valid_d = 1'b0;
   end

   always_ff @(posedge aclk or posedge areset)
      if (areset) begin
         aw_valid_q <= 1'b0;
         aw_addr_q <= 3'd0;
         w_valid_q <= 1'b0;
         w_data_q <= 8'd0;
         b_valid_q <= 1'b0;
         r_valid_q <= 1'b0;
         r_data_q <= 32'd0;
         enable_q <= 1'b0;
         use_int_q <= 1'b1;
         cpb_q <= 8'd4;
         underrun_q <= 1'b0;
         count_q <= 16'd0;
         cnt_q <= 8'd0;
         sync_q <= 3'd0;
         wclk_q <= 1'b0;
         state_q <= IDLE;
         shift_q <= 8'd0;
         last_q <= 1'b0;
         bit_cnt_q <= 3'd0;
         byte_cnt_q <= 16'd0;
         gate_q <= 1'b0;
         data_q <= 1'b0;
         hold_q <= 8'd0;
         hold_last_q <= 1'b0;
         hold_valid_q <= 1'b0;
      end else begin
         aw_valid_q <= aw_valid_d;
         aw_addr_q <= aw_addr_d;
         w_valid_q <= w_valid_d;
         w_data_q <= w_data_d;
         b_valid_q <= b_valid_d;
         r_valid_q <= r_valid_d;
         r_data_q <= r_data_d;
         enable_q <= enable_d;
         use_int_q <= use_int_d;
         cpb_q <= cpb_d;
         underrun_q <= underrun_d;
         count_q <= count_d;
         cnt_q <= cnt_d;
         sync_q <= sync_d;
         wclk_q <= wclk_d;
         state_q <= state_d;
         shift_q <= shift_d;
         last_q <= last_d;
         bit_cnt_q <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         gate_q <= gate_d;
         data_q <= data_d;
         hold_q <= hold_d;
         hold_last_q <= hold_last_d;
         hold_valid_q <= hold_valid_d;
      end

   assign esdi_write_gate_o = gate_q;
   assign esdi_write_data_o = data_q;
   assign esdi_write_clock_o = wclk_q;
endmodule

// File: tb/tb_axi_esdi_write_datapath.sv
// tb_axi_esdi_write_datapath: scoreboard bench; stimulus queues expected wire bits, gate
// lengths and CSR read data, independent monitors pop and compare what the DUT presents.
`timescale 1ns/1ps
module tb_axi_esdi_write_datapath;
   typedef struct {
      logic [31:0] d;
      logic [31:0] m;
      int          id;
   } rd_t;

   logic aclk = 1'b0, areset = 1'b1, ref_clk = 1'b1;
   logic gate, wdat, wclk;
   int   tests = 0, fails = 0;
   logic exp_bits[$];
   int   exp_gate[$];
   rd_t  exp_rd[$];
   rd_t  e_rd;
   int   exp_period = 4, rises = 0, since = 0;
   logic ignore_wire = 1'b0, pw = 1'b0, pg = 1'b0;

   axi_esdi_write_datapath_if bus ();

   axi_esdi_write_datapath #(.MAX_BYTES_PER_PACKET(4)) dut (
      .aclk(aclk),
      .areset(areset),
      .bus(bus),
      .esdi_reference_clock_i(ref_clk),
      .esdi_write_gate_o(gate),
      .esdi_write_data_o(wdat),
      .esdi_write_clock_o(wclk)
   );

   always #5 aclk = ~aclk;
   initial begin
      #3;
      forever #35 ref_clk = ~ref_clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Wire monitor: one bit per write-clock rise while the gate is high.
   initial forever begin
      @(negedge aclk);
      since++;
      if (wclk && !pw && gate) begin
         if (rises > 0) check("bit_period", since, exp_period);
         rises++;
         if (!ignore_wire) begin
            check("bit_expected", 32'(exp_bits.size() > 0), 32'd1);
            if (exp_bits.size() > 0) check("wire_bit", 32'(wdat), 32'(exp_bits.pop_front()));
         end
      end
      if (wclk && !pw) since = 0;
      if (!gate && pg && !ignore_wire) begin
         check("gate_expected", 32'(exp_gate.size() > 0), 32'd1);
         if (exp_gate.size() > 0) check("gate_bits", rises, exp_gate.pop_front());
      end
      if (!gate) rises = 0;
      pw = wclk;
      pg = gate;
   end

   initial forever begin
      @(negedge aclk);
      if (bus.csr_rvalid && bus.csr_rready) begin
         check("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
         if (exp_rd.size() > 0) begin
            e_rd = exp_rd.pop_front();
            check($sformatf("csr_rd%0d", e_rd.id), bus.csr_rdata & e_rd.m, e_rd.d & e_rd.m);
         end
      end
   end

   task automatic csr_wr(input logic [4:0] a, input logic [31:0] d);
      int n;
      @(negedge aclk);
      bus.csr_awaddr = a;
      bus.csr_awvalid = 1'b1;
      bus.csr_wdata = d;
      bus.csr_wvalid = 1'b1;
      n = 0;
      while (!(bus.csr_awready && bus.csr_wready) && n < 50) begin @(negedge aclk); n++; end
      @(negedge aclk);
      bus.csr_awvalid = 1'b0;
      bus.csr_wvalid = 1'b0;
      n = 0;
      while (!bus.csr_bvalid && n < 50) begin @(negedge aclk); n++; end
      check("csr_bvalid", 32'(bus.csr_bvalid), 32'd1);
   endtask

   task automatic csr_rd(input logic [4:0] a, input logic [31:0] e, input logic [31:0] m, input int id);
      int n;
      rd_t r;
      r.d = e;
      r.m = m;
      r.id = id;
      exp_rd.push_back(r);
      @(negedge aclk);
      bus.csr_araddr = a;
      bus.csr_arvalid = 1'b1;
      n = 0;
      while (!bus.csr_arready && n < 50) begin @(negedge aclk); n++; end
      @(negedge aclk);
      bus.csr_arvalid = 1'b0;
      check("csr_rvalid_latency", 32'(bus.csr_rvalid), 32'd1);
      @(negedge aclk);
   endtask

   task automatic beat(input logic [7:0] d, input logic l);
      int n;
      @(negedge aclk);
      bus.s_tvalid = 1'b1;
      bus.s_tdata = d;
      bus.s_tlast = l;
      n = 0;
      while (!bus.s_tready && n < 2000) begin @(negedge aclk); n++; end
      check("beat_accepted", 32'(bus.s_tready), 32'd1);
   endtask

   task automatic stream_idle();
      @(negedge aclk);
      bus.s_tvalid = 1'b0;
      bus.s_tlast = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
   endtask

   task automatic wait_wire();
      int n;
      n = 0;
      while ((exp_bits.size() != 0 || exp_gate.size() != 0) && n < 3000) begin @(negedge aclk); n++; end
      check("wire_done", 32'(exp_bits.size() + exp_gate.size()), 32'd0);
      repeat (4) @(negedge aclk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
   end

   initial begin
      int n;
      logic pwl;
      logic [7:0] pk [6];
      bus.csr_awvalid = 1'b0; bus.csr_awaddr = 5'd0; bus.csr_wvalid = 1'b0; bus.csr_wdata = 32'd0;
      bus.csr_bready = 1'b1; bus.csr_arvalid = 1'b0; bus.csr_araddr = 5'd0; bus.csr_rready = 1'b1;
      bus.s_tvalid = 1'b0; bus.s_tdata = 8'd0; bus.s_tlast = 1'b0;
      repeat (3) @(negedge aclk);
      check("rst_gate", 32'(gate), 32'd0);
      check("rst_data", 32'(wdat), 32'd0);
      check("rst_wclk", 32'(wclk), 32'd0);
      check("rst_tready", 32'(bus.s_tready), 32'd0);
      check("rst_bvalid", 32'(bus.csr_bvalid), 32'd0);
      check("rst_rvalid", 32'(bus.csr_rvalid), 32'd0);
      check("rst_awready", 32'(bus.csr_awready), 32'd1);
      check("rst_wready", 32'(bus.csr_wready), 32'd1);
      check("rst_arready", 32'(bus.csr_arready), 32'd1);
      areset = 1'b0;
      csr_rd(5'h00, 32'h2, 32'hffff_ffff, 0);
      csr_rd(5'h04, 32'h4, 32'hffff_ffff, 1);
      csr_rd(5'h08, 32'h0, 32'hffff_ffff, 2);

      // internal clock, cpb=4, two-byte packet
      csr_wr(5'h00, 32'h3);
      push_byte(8'hA5); push_byte(8'h3C); exp_gate.push_back(16);
      beat(8'hA5, 1'b0); beat(8'h3C, 1'b1); stream_idle();
      wait_wire();
      csr_rd(5'h08, 32'h0002_0000, 32'hffff_ffff, 3);

      // underrun then drain
      push_byte(8'hFF); exp_gate.push_back(8);
      beat(8'hFF, 1'b0); stream_idle();
      wait_wire();
      csr_rd(5'h08, 32'h2, 32'h3, 4);
      beat(8'h11, 1'b0); beat(8'h22, 1'b1); stream_idle();
      repeat (60) @(negedge aclk);
      csr_wr(5'h00, 32'h7);
      csr_rd(5'h08, 32'h0002_0000, 32'hffff_0003, 5);
      csr_rd(5'h00, 32'h3, 32'hffff_ffff, 6);

      // length limit of 4 splits a 6-byte packet
      pk = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      for (int i = 0; i < 6; i++) push_byte(pk[i]);
      exp_gate.push_back(32); exp_gate.push_back(16);
      for (int i = 0; i < 6; i++) beat(pk[i], i == 5);
      stream_idle();
      wait_wire();
      csr_rd(5'h08, 32'h0002_0000, 32'hffff_0003, 7);

      // cpb=1 behaves as 2
      csr_wr(5'h04, 32'h1);
      csr_rd(5'h04, 32'h1, 32'hffff_ffff, 8);
      csr_rd(5'h1C, 32'h0, 32'hffff_ffff, 9);
      exp_period = 2;
      push_byte(8'h5A); exp_gate.push_back(8);
      beat(8'h5A, 1'b1); stream_idle();
      wait_wire();
      csr_wr(5'h04, 32'h4);

      // external reference clock, period 7 aclk
      csr_wr(5'h00, 32'h1);
      exp_period = 7;
      push_byte(8'h81); exp_gate.push_back(8);
      beat(8'h81, 1'b1); stream_idle();
      wait_wire();
      n = 0;
      pwl = wclk;
      repeat (70) begin @(negedge aclk); if (wclk && !pwl) n++; pwl = wclk; end
      check("ext_wclk_rises", n, 10);

      // enable cleared mid-byte
      csr_wr(5'h00, 32'h3);
      exp_period = 4;
      ignore_wire = 1'b1;
      beat(8'hC3, 1'b0); beat(8'h99, 1'b0); stream_idle();
      n = 0;
      while (rises < 4 && n < 500) begin @(negedge aclk); n++; end
      check("reached_bit3", 32'(rises >= 4), 32'd1);
      csr_wr(5'h00, 32'h2);
      @(posedge aclk); #1;
      check("abort_gate", 32'(gate), 32'd0);
      check("abort_data", 32'(wdat), 32'd0);
      check("abort_wclk", 32'(wclk), 32'd0);
      csr_rd(5'h08, 32'h2, 32'h3, 10);
      beat(8'hAA, 1'b0); beat(8'hBB, 1'b1); stream_idle();
      check("drain_done_tready", 32'(bus.s_tready), 32'd0);
      repeat (10) @(negedge aclk);
      ignore_wire = 1'b0;
      check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
